// File: rtl/dm_dmi_pkg.sv
// Shared DMI request/response types, op encodings and sequencer states.
package dm_dmi_pkg;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
    logic [1:0]  op;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } dtm_op_e;

  localparam logic [1:0] DTM_SUCCESS = 2'd0;
  localparam logic [1:0] DTM_ERR     = 2'd2;
  localparam logic [1:0] DTM_BUSY    = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } seq_state_e;

endpackage

// File: rtl/dmi_resp_fifo.sv
// Response FIFO with registered storage; clear_i empties it and drops a same-cycle push.
module dmi_resp_fifo
  import dm_dmi_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          push,
  input  logic          pop,
  input  dmi_resp_t     din,
  output logic [CW-1:0] count,
  output dmi_resp_t     head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dmi_resp_t     mem [DEPTH];
  logic [PW-1:0] wptr, rptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= nxt(wptr);
      if (pop)  rptr <= nxt(rptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push && !clear_i) begin
      mem[wptr] <= din;
    end
  end

  assign head = mem[rptr];

endmodule

// File: rtl/dmi_req_sequencer.sv
// Executes DMI requests as single reg-bus accesses and queues their responses.
// Optional WAIT timeout is enabled by defining DMI_REG_TIMEOUT_EN.
module dmi_req_sequencer
  import dm_dmi_pkg::*;
#(
  parameter int unsigned DEPTH          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic [40:0] dmi_req_i,
  input  logic        dmi_req_valid_i,
  output logic        dmi_req_ready_o,
  output logic [33:0] dmi_resp_o,
  output logic        dmi_resp_valid_o,
  input  logic        dmi_resp_ready_i,
  output logic        reg_req_o,
  output logic        reg_we_o,
  output logic [6:0]  reg_addr_o,
  output logic [31:0] reg_wdata_o,
  input  logic        reg_gnt_i,
  input  logic        reg_rvalid_i,
  input  logic [31:0] reg_rdata_i,
  input  logic        reg_err_i
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  seq_state_e    state_q, state_d;
  dmi_req_t      req;
  dmi_resp_t     head, push_data;
  logic [CW-1:0] count;
  logic          push, pop, accept, is_rw, timeout;
  logic          we_q;
  logic [6:0]    addr_q;
  logic [31:0]   wdata_q;

  assign req              = dmi_req_i;
  assign is_rw            = (req.op == READ) || (req.op == WRITE);
  assign dmi_req_ready_o  = !rst_i && (state_q == IDLE) && !clear_i && (count < CW'(DEPTH));
  assign accept           = dmi_req_valid_i && dmi_req_ready_o;
  assign dmi_resp_valid_o = (count != '0);
  assign pop              = dmi_resp_valid_o && dmi_resp_ready_i;
  assign dmi_resp_o       = head;
  assign reg_we_o         = we_q;
  assign reg_addr_o       = addr_q;
  assign reg_wdata_o      = wdata_q;

`ifdef DMI_REG_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt_q;

  // Held at zero outside WAIT, so every entry to WAIT starts a fresh count.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != WAIT) wait_cnt_q <= '0;
    else                          wait_cnt_q <= wait_cnt_q + 1'b1;
  end

  assign timeout = (state_q == WAIT) && (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept && is_rw) begin
      we_q    <= (req.op == WRITE);
      addr_q  <= req.addr;
      wdata_q <= req.data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_rw) state_d = REQ;
      // A grant coinciding with clear still launches an access; drain its completion.
      REQ:     if (clear_i)        state_d = reg_gnt_i ? DRAIN : IDLE;
               else if (reg_gnt_i) state_d = WAIT;
      // A completion coinciding with clear leaves nothing to drain.
      WAIT:    if (reg_rvalid_i)            state_d = IDLE;
               else if (clear_i || timeout) state_d = DRAIN;
      DRAIN:   if (reg_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    reg_req_o = (state_q == REQ);
    case (state_q)
      IDLE: if (accept && !is_rw) begin
        push           = 1'b1;
        push_data.resp = (req.op == NOP) ? DTM_SUCCESS : DTM_ERR;
      end
      WAIT: if (reg_rvalid_i) begin
        push           = 1'b1;
        push_data.data = we_q ? 32'h0 : reg_rdata_i;
        push_data.resp = reg_err_i ? DTM_ERR : DTM_SUCCESS;
      end else if (timeout) begin
        push           = 1'b1;
        push_data.resp = DTM_BUSY;
      end
      default: ;
    endcase
  end

  dmi_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push    (push),
    .pop     (pop),
    .din     (push_data),
    .count   (count),
    .head    (head)
  );

endmodule

// File: tb/tb_dmi_req_sequencer.sv
// Directed bench for dmi_req_sequencer; timeout scenario runs when DMI_REG_TIMEOUT_EN is defined.
module tb_dmi_req_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i, clear_i;
  logic [40:0] dmi_req;
  logic        dmi_req_valid, dmi_req_ready;
  logic [33:0] dmi_resp;
  logic        dmi_resp_valid, dmi_resp_ready;
  logic        reg_req, reg_we, reg_gnt, reg_rvalid, reg_err;
  logic [6:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  dmi_req_sequencer #(.DEPTH(2), .TIMEOUT_CYCLES(8)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .clear_i          (clear_i),
    .dmi_req_i        (dmi_req),
    .dmi_req_valid_i  (dmi_req_valid),
    .dmi_req_ready_o  (dmi_req_ready),
    .dmi_resp_o       (dmi_resp),
    .dmi_resp_valid_o (dmi_resp_valid),
    .dmi_resp_ready_i (dmi_resp_ready),
    .reg_req_o        (reg_req),
    .reg_we_o         (reg_we),
    .reg_addr_o       (reg_addr),
    .reg_wdata_o      (reg_wdata),
    .reg_gnt_i        (reg_gnt),
    .reg_rvalid_i     (reg_rvalid),
    .reg_rdata_i      (reg_rdata),
    .reg_err_i        (reg_err)
  );

  // Drives one request from posedge+1; grant is held high, rvalid follows the grant
  // by one cycle. Returns accept-to-valid latency (-1 if none) and pops the response.
  task automatic drive_access(input logic [40:0] r, input logic [31:0] rd, input logic er,
                              output int lat, output logic [33:0] rsp, output logic rdy,
                              output logic we, output logic [6:0] ad, output logic [31:0] wd);
    bit fire = 0, seen = 0;
    lat = -1; rsp = '0; we = 0; ad = '0; wd = '0;
    reg_rdata = rd; reg_err = er;
    dmi_req = r; dmi_req_valid = 1'b1;
    @(negedge clk_i); rdy = dmi_req_ready;
    @(posedge clk_i); #1 dmi_req_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_i);
      if (dmi_resp_valid) begin lat = n; rsp = dmi_resp; break; end
      if (reg_req && !seen) begin
        seen = 1; fire = 1; we = reg_we; ad = reg_addr; wd = reg_wdata;
      end
      @(posedge clk_i); #1;
      reg_rvalid = fire;
      fire = 0;
    end
    reg_rvalid = 1'b0;
    dmi_resp_ready = 1'b1;
    @(posedge clk_i); #1 dmi_resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks += 4;
    if (dmi_req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", dmi_req_ready); end
    if (dmi_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", dmi_resp_valid); end
    if (reg_req !== 1'b0) begin errors++; $display("FAIL rst_reg_req: got %b want 0", reg_req); end
    if ({reg_we, reg_addr, reg_wdata, dmi_resp} !== '0) begin
      errors++; $display("FAIL rst_outputs: got %h want 0", {reg_we, reg_addr, reg_wdata, dmi_resp});
    end
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (dmi_req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", dmi_req_ready); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_write;
    int lat; logic [33:0] rsp; logic rdy, we; logic [6:0] ad; logic [31:0] wd;
    drive_access({7'h10, 32'hCAFE_F00D, 2'd2}, 32'h1234_5678, 1'b0, lat, rsp, rdy, we, ad, wd);
    checks += 6;
    if (rdy !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", rdy); end
    if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d want 3", lat); end
    if (rsp !== 34'h0) begin errors++; $display("FAIL wr_resp: got %h want 0", rsp); end
    if (we !== 1'b1) begin errors++; $display("FAIL wr_we: got %b want 1", we); end
    if (ad !== 7'h10) begin errors++; $display("FAIL wr_addr: got %h want 10", ad); end
    if (wd !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr_wdata: got %h want cafef00d", wd); end
  endtask

  task automatic test_read;
    int lat; logic [33:0] rsp; logic rdy, we; logic [6:0] ad; logic [31:0] wd;
    drive_access({7'h11, 32'h0, 2'd1}, 32'hDEAD_BEEF, 1'b0, lat, rsp, rdy, we, ad, wd);
    checks += 4;
    if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d want 3", lat); end
    if (rsp !== {32'hDEAD_BEEF, 2'd0}) begin errors++; $display("FAIL rd_resp: got %h want %h", rsp, {32'hDEAD_BEEF, 2'd0}); end
    if (we !== 1'b0) begin errors++; $display("FAIL rd_we: got %b want 0", we); end
    if (ad !== 7'h11) begin errors++; $display("FAIL rd_addr: got %h want 11", ad); end
    drive_access({7'h12, 32'h0, 2'd1}, 32'h0, 1'b1, lat, rsp, rdy, we, ad, wd);
    checks += 2;
    if (lat !== 3) begin errors++; $display("FAIL rd_err_latency: got %0d want 3", lat); end
    if (rsp !== {32'h0, 2'd2}) begin errors++; $display("FAIL rd_err_resp: got %h want 2", rsp); end
  endtask

  task automatic test_nop_reserved;
    int lat; logic [33:0] rsp; logic rdy, we; logic [6:0] ad; logic [31:0] wd;
    drive_access({7'h05, 32'h5555_0000, 2'd0}, 32'h0, 1'b0, lat, rsp, rdy, we, ad, wd);
    checks += 2;
    if (lat !== 1) begin errors++; $display("FAIL nop_latency: got %0d want 1", lat); end
    if (rsp !== 34'h0) begin errors++; $display("FAIL nop_resp: got %h want 0", rsp); end
    drive_access({7'h06, 32'h0000_AAAA, 2'd3}, 32'h0, 1'b0, lat, rsp, rdy, we, ad, wd);
    checks += 2;
    if (lat !== 1) begin errors++; $display("FAIL rsv_latency: got %0d want 1", lat); end
    if (rsp !== {32'h0, 2'd2}) begin errors++; $display("FAIL rsv_resp: got %h want 2", rsp); end
  endtask

  task automatic test_back_to_back;
    dmi_resp_ready = 1'b0;
    dmi_req = {7'h01, 32'h0, 2'd0}; dmi_req_valid = 1'b1;
    @(posedge clk_i); #1 dmi_req = {7'h02, 32'h0, 2'd3};
    @(negedge clk_i); checks++;
    if (dmi_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_one: got %b want 1", dmi_req_ready); end
    @(posedge clk_i); #1 dmi_req = {7'h03, 32'h0, 2'd0};
    @(negedge clk_i); checks++;
    if (dmi_req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b want 0", dmi_req_ready); end
    @(posedge clk_i); #1;
    @(negedge clk_i); checks += 2;
    if (dmi_req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_held: got %b want 0", dmi_req_ready); end
    if ({dmi_resp_valid, dmi_resp} !== {1'b1, 34'h0}) begin errors++; $display("FAIL b2b_head0: got %h want 1_0", {dmi_resp_valid, dmi_resp}); end
    dmi_resp_ready = 1'b1;
    @(posedge clk_i); #1 dmi_resp_ready = 1'b0;
    @(negedge clk_i); checks += 2;
    if (dmi_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_pop: got %b want 1", dmi_req_ready); end
    if (dmi_resp !== {32'h0, 2'd2}) begin errors++; $display("FAIL b2b_head1: got %h want 2", dmi_resp); end
    @(posedge clk_i); #1 dmi_req_valid = 1'b0;
    @(negedge clk_i); checks++;
    if (dmi_req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_third: got %b want 0", dmi_req_ready); end
    dmi_resp_ready = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i); checks++;
    if ({dmi_resp_valid, dmi_resp} !== {1'b1, 34'h0}) begin errors++; $display("FAIL b2b_head2: got %h want 1_0", {dmi_resp_valid, dmi_resp}); end
    @(posedge clk_i); #1 dmi_resp_ready = 1'b0;
    @(negedge clk_i); checks++;
    if (dmi_resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", dmi_resp_valid); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_clear_wait;
    int lat; logic [33:0] rsp; logic rdy, we; logic [6:0] ad; logic [31:0] wd;
    dmi_resp_ready = 1'b0;
    dmi_req = {7'h00, 32'h0, 2'd0}; dmi_req_valid = 1'b1;
    @(posedge clk_i); #1 dmi_req = {7'h22, 32'h0, 2'd1};
    @(posedge clk_i); #1 dmi_req_valid = 1'b0;
    @(negedge clk_i); checks++;
    if (reg_req !== 1'b1) begin errors++; $display("FAIL clr_reg_req: got %b want 1", reg_req); end
    @(posedge clk_i); #1 clear_i = 1'b1;
    @(negedge clk_i); checks++;
    if (dmi_resp_valid !== 1'b1) begin errors++; $display("FAIL clr_pre_valid: got %b want 1", dmi_resp_valid); end
    @(posedge clk_i); #1 clear_i = 1'b0;
    @(negedge clk_i); checks += 3;
    if (dmi_resp_valid !== 1'b0) begin errors++; $display("FAIL clr_flushed: got %b want 0", dmi_resp_valid); end
    if (dmi_req_ready !== 1'b0) begin errors++; $display("FAIL clr_drain_ready: got %b want 0", dmi_req_ready); end
    if (reg_req !== 1'b0) begin errors++; $display("FAIL clr_drain_req: got %b want 0", reg_req); end
    @(posedge clk_i); #1 reg_rdata = 32'hAAAA_5555; reg_rvalid = 1'b1;
    @(posedge clk_i); #1 reg_rvalid = 1'b0;
    @(negedge clk_i); checks += 2;
    if (dmi_resp_valid !== 1'b0) begin errors++; $display("FAIL clr_discard: got %b want 0", dmi_resp_valid); end
    if (dmi_req_ready !== 1'b1) begin errors++; $display("FAIL clr_idle_ready: got %b want 1", dmi_req_ready); end
    @(posedge clk_i); #1;
    drive_access({7'h11, 32'h0, 2'd1}, 32'h5555_AAAA, 1'b0, lat, rsp, rdy, we, ad, wd);
    checks += 2;
    if (lat !== 3) begin errors++; $display("FAIL clr_next_latency: got %0d want 3", lat); end
    if (rsp !== {32'h5555_AAAA, 2'd0}) begin errors++; $display("FAIL clr_next_resp: got %h want %h", rsp, {32'h5555_AAAA, 2'd0}); end
  endtask

`ifdef DMI_REG_TIMEOUT_EN
  task automatic test_timeout;
    int got = -1;
    dmi_resp_ready = 1'b0;
    dmi_req = {7'h33, 32'h0, 2'd1}; dmi_req_valid = 1'b1;
    @(posedge clk_i); #1 dmi_req_valid = 1'b0;
    @(posedge clk_i); #1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_i);
      if (dmi_resp_valid) begin got = n; break; end
    end
    checks += 3;
    if (got !== 9) begin errors++; $display("FAIL to_latency: got %0d want 9", got); end
    if (dmi_resp !== {32'h0, 2'd3}) begin errors++; $display("FAIL to_resp: got %h want 3", dmi_resp); end
    if (dmi_req_ready !== 1'b0) begin errors++; $display("FAIL to_drain_ready: got %b want 0", dmi_req_ready); end
    dmi_resp_ready = 1'b1;
    @(posedge clk_i); #1 dmi_resp_ready = 1'b0; reg_rdata = 32'hFFFF_0001; reg_rvalid = 1'b1;
    @(posedge clk_i); #1 reg_rvalid = 1'b0;
    @(negedge clk_i); checks += 2;
    if (dmi_resp_valid !== 1'b0) begin errors++; $display("FAIL to_late_discard: got %b want 0", dmi_resp_valid); end
    if (dmi_req_ready !== 1'b1) begin errors++; $display("FAIL to_idle_ready: got %b want 1", dmi_req_ready); end
    @(posedge clk_i); #1;
  endtask
`endif

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; dmi_req = '0; dmi_req_valid = 1'b0; dmi_resp_ready = 1'b0;
    reg_gnt = 1'b1; reg_rvalid = 1'b0; reg_rdata = '0; reg_err = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_nop_reserved();
    test_back_to_back();
    test_clear_wait();
`ifdef DMI_REG_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
